// File: rtl/ysyx_22050710_mdu_ctrl.sv
// Iterative multiply/divide controller for the EX stage: radix-2 shift-add multiply,
// radix-2 restoring divide, and a direct path for divide-by-zero and signed overflow.
module ysyx_22050710_mdu_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_ALUctr,
    input  logic        i_word_cut,
    input  logic [63:0] i_src_a,
    input  logic [63:0] i_src_b,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [63:0] o_result,
    output logic        o_busy
);
    localparam logic [4:0] OP_MUL  = 5'b01010;
    localparam logic [4:0] OP_DIV  = 5'b01011;
    localparam logic [4:0] OP_REM  = 5'b01101;
    localparam logic [4:0] OP_REMU = 5'b01110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] opA_q, opB_q, acc_q, result_q;
    logic        isMul_q, isRem_q, word_q, negQ_q, negR_q, valid_q;

    function automatic logic [63:0] wordFix(input logic word, input logic [63:0] v);
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    logic        opOk, inMul, inSigned, inRem, accept, divZero, overflow, bypass, signA, signB;
    logic [63:0] srcA, srcB, magA, magB, bypassRes;

    always_comb begin
        opOk     = (i_ALUctr >= OP_MUL) && (i_ALUctr <= OP_REMU);
        inMul    = (i_ALUctr == OP_MUL);
        inSigned = (i_ALUctr == OP_MUL) || (i_ALUctr == OP_DIV) || (i_ALUctr == OP_REM);
        inRem    = (i_ALUctr == OP_REM) || (i_ALUctr == OP_REMU);
        srcA     = i_src_a;
        srcB     = i_src_b;
        if (i_word_cut) begin
            srcA = {{32{inSigned & i_src_a[31]}}, i_src_a[31:0]};
            srcB = {{32{inSigned & i_src_b[31]}}, i_src_b[31:0]};
        end
        accept   = i_valid && (state_q == IDLE) && !i_flush && opOk;
        divZero  = i_word_cut ? (i_src_b[31:0] == 32'd0) : (i_src_b == 64'd0);
        overflow = inSigned && !inMul &&
                   (i_word_cut ? (i_src_a[31:0] == 32'h8000_0000 && i_src_b[31:0] == 32'hFFFF_FFFF)
                               : (i_src_a == 64'h8000_0000_0000_0000 && i_src_b == {64{1'b1}}));
        bypass   = !inMul && (divZero || overflow);
        if (divZero) bypassRes = inRem ? srcA : {64{1'b1}};
        else         bypassRes = inRem ? 64'd0 : srcA;
        signA    = inSigned && srcA[63];
        signB    = inSigned && srcB[63];
        magA     = signA ? -srcA : srcA;
        magB     = signB ? -srcB : srcB;
    end

    // One iteration of each datapath; the final iteration feeds the result register directly.
    logic [63:0] mulAcc, remNext, quotNext, qAdj, rAdj, finalRes;
    logic [64:0] remShift, diff;

    always_comb begin
        mulAcc   = opB_q[0] ? (acc_q + opA_q) : acc_q;
        remShift = {acc_q, opA_q[63]};
        diff     = remShift - {1'b0, opB_q};
        remNext  = diff[64] ? remShift[63:0] : diff[63:0];
        quotNext = {opA_q[62:0], ~diff[64]};
        qAdj     = negQ_q ? -quotNext : quotNext;
        rAdj     = negR_q ? -remNext : remNext;
        finalRes = isMul_q ? mulAcc : (isRem_q ? rAdj : qAdj);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            opA_q    <= 64'd0;
            opB_q    <= 64'd0;
            acc_q    <= 64'd0;
            result_q <= 64'd0;
            isMul_q  <= 1'b0;
            isRem_q  <= 1'b0;
            word_q   <= 1'b0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (i_flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        isMul_q <= inMul;
                        isRem_q <= inRem;
                        word_q  <= i_word_cut;
                        negQ_q  <= signA ^ signB;
                        negR_q  <= signA;
                        acc_q   <= 64'd0;
                        cnt_q   <= i_word_cut ? 6'd31 : 6'd63;
                        if (bypass) begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= wordFix(i_word_cut, bypassRes);
                        end else begin
                            state_q <= BUSY;
                            // W divides start with the 32-bit magnitude in the upper half so its MSB shifts out first.
                            opA_q   <= inMul ? srcA : (i_word_cut ? (magA << 32) : magA);
                            opB_q   <= inMul ? srcB : magB;
                        end
                    end
                end
                BUSY: begin
                    if (isMul_q) begin
                        acc_q <= mulAcc;
                        opA_q <= opA_q << 1;
                        opB_q <= opB_q >> 1;
                    end else begin
                        acc_q <= remNext;
                        opA_q <= quotNext;
                    end
                    if (cnt_q == 6'd0) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= wordFix(word_q, finalRes);
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_busy   = (state_q != IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_ysyx_22050710_mdu_ctrl.sv
// Self-checking bench for ysyx_22050710_mdu_ctrl: vector table, random ops against an
// arithmetic reference model, and hand-written flush/reset/handshake sequences.
module tb_ysyx_22050710_mdu_ctrl;
    localparam logic [4:0] MUL  = 5'b01010;
    localparam logic [4:0] DIV  = 5'b01011;
    localparam logic [4:0] DIVU = 5'b01100;
    localparam logic [4:0] REM  = 5'b01101;
    localparam logic [4:0] REMU = 5'b01110;

    logic        i_clk, i_rst, i_valid, o_ready, i_word_cut, i_flush, o_valid, i_ready, o_busy;
    logic [4:0]  i_ALUctr;
    logic [63:0] i_src_a, i_src_b, o_result;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];

    ysyx_22050710_mdu_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_ALUctr(i_ALUctr), .i_word_cut(i_word_cut), .i_src_a(i_src_a), .i_src_b(i_src_b),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] expRes;
        int          expLat;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference results from the language's own arithmetic, with the RISC-V corner cases.
    function automatic logic [63:0] modelResult(input logic [4:0] op, input logic w,
                                                input logic [63:0] a, input logic [63:0] b);
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa64, sb64;
        logic [31:0] r32;
        logic [63:0] r64;
        sa32 = a[31:0];
        sb32 = b[31:0];
        sa64 = a;
        sb64 = b;
        r32 = 32'd0;
        r64 = 64'd0;
        if (w) begin
            case (op)
                MUL:  r32 = a[31:0] * b[31:0];
                DIV:  if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF;
                      else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
                      else r32 = sa32 / sb32;
                DIVU: if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF; else r32 = a[31:0] / b[31:0];
                REM:  if (b[31:0] == 32'd0) r32 = a[31:0];
                      else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = 32'd0;
                      else r32 = sa32 % sb32;
                default: if (b[31:0] == 32'd0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
            endcase
            r64 = {{32{r32[31]}}, r32};
        end else begin
            case (op)
                MUL:  r64 = a * b;
                DIV:  if (b == 64'd0) r64 = {64{1'b1}};
                      else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r64 = a;
                      else r64 = sa64 / sb64;
                DIVU: if (b == 64'd0) r64 = {64{1'b1}}; else r64 = a / b;
                REM:  if (b == 64'd0) r64 = a;
                      else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r64 = 64'd0;
                      else r64 = sa64 % sb64;
                default: if (b == 64'd0) r64 = a; else r64 = a % b;
            endcase
        end
        return r64;
    endfunction

    function automatic int expLatency(input logic [4:0] op, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = (op == DIV || op == REM) &&
               (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                  : (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}));
        if (op != MUL && (zero || ovf)) return 1;
        return w ? 33 : 65;
    endfunction

    // Drives one op just after edge T and waits for o_valid, measuring edges from T.
    task automatic applyStimulus(input logic [4:0] op, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] expRes,
                                 input int expLat, input string name);
        int lat;
        bit seen;
        logic [63:0] exp;
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_ALUctr = op; i_word_cut = w; i_src_a = a; i_src_b = b;
        sb.push_back(expRes);
        lat = 0;
        seen = 1'b0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(posedge i_clk); #1;
            if (k == 1) i_valid = 1'b0;
            if (o_valid) begin
                seen = 1'b1;
                lat = k;
            end
        end
        exp = sb.pop_front();
        if (!seen) begin
            checkOutput({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
            checkOutput({name, "_result"}, o_result, exp);
        end
    endtask

    task automatic handshake(input string name);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        checkOutput({name, "_released"}, 64'(o_valid), 64'd0);
    endtask

    task automatic watchNoValid(input string name, input int cycles);
        bit anyValid;
        anyValid = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) anyValid = 1'b1;
        end
        checkOutput(name, 64'(anyValid), 64'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ALUctr = 5'd0; i_word_cut = 1'b0;
        i_src_a = 64'd0; i_src_b = 64'd0; i_flush = 1'b0; i_ready = 1'b0;

        vecs[0]  = '{MUL,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_7_m3"};
        vecs[1]  = '{DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf"};
        vecs[2]  = '{DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_by0"};
        vecs[3]  = '{REMU, 1'b0, 64'd100, 64'd0, 64'd100, 1, "remu_by0"};
        vecs[4]  = '{REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_m7_2"};
        vecs[5]  = '{REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'h0000_0000_0000_000F, 33, "remuw"};
        vecs[6]  = '{DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div_m100_7"};
        vecs[7]  = '{REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem_ovf"};
        vecs[8]  = '{MUL,  1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw"};
        vecs[9]  = '{DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'h0000_0000_0FFF_FFFF, 33, "divuw"};
        vecs[10] = '{REM,  1'b1, 64'h1234_5678_FFFF_FFF7, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 33, "remw_m9_4"};
        vecs[11] = '{DIV,  1'b0, 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div_by0"};
        vecs[12] = '{DIV,  1'b1, 64'd55, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divw_by0_hi"};
        vecs[13] = '{DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65, "divu_max_3"};

        #1;
        checkOutput("rst_ready", 64'(o_ready), 64'd1);
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_result", o_result, 64'd0);
        @(posedge i_clk); #1;
        checkOutput("rst_held_ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
                          vecs[i].expRes, vecs[i].expLat, vecs[i].name);
            handshake(vecs[i].name);
        end

        for (int i = 0; i < 12; i++) begin
            logic [4:0] op;
            logic w;
            logic [63:0] a, b;
            op = 5'(10 + $urandom_range(0, 4));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) b = 64'($urandom_range(0, 9));
            applyStimulus(op, w, a, b, modelResult(op, w, a, b), expLatency(op, w, a, b),
                          $sformatf("rand%0d", i));
            handshake($sformatf("rand%0d", i));
        end

        // Unsupported op codes and flush-with-valid must leave the FSM idle.
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_ALUctr = 5'b01111; i_src_a = 64'd3; i_src_b = 64'd4;
        @(posedge i_clk); #1;
        checkOutput("badop_busy", 64'(o_busy), 64'd0);
        i_ALUctr = 5'b00000;
        @(posedge i_clk); #1;
        checkOutput("badop0_ready", 64'(o_ready), 64'd1);
        i_ALUctr = MUL; i_flush = 1'b1;
        @(posedge i_clk); #1;
        checkOutput("flush_idle_busy", 64'(o_busy), 64'd0);
        i_valid = 1'b0; i_flush = 1'b0;

        // Result holds while the consumer stalls, then the handoff cycle does not accept.
        applyStimulus(MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "stall_mul");
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            checkOutput($sformatf("stall_valid%0d", k), 64'(o_valid), 64'd1);
            checkOutput($sformatf("stall_result%0d", k), o_result, 64'hFFFF_FFFF_FFFF_FFEB);
        end
        i_ready = 1'b1; i_valid = 1'b1; i_ALUctr = MUL; i_word_cut = 1'b0;
        i_src_a = 64'd5; i_src_b = 64'd6;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        checkOutput("handoff_ready", 64'(o_ready), 64'd1);
        checkOutput("handoff_valid", 64'(o_valid), 64'd0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        checkOutput("accept_after_handoff", 64'(o_busy), 64'd1);
        repeat (9) @(posedge i_clk);
        #1 i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        checkOutput("flush_busy_ready", 64'(o_ready), 64'd1);
        checkOutput("flush_busy_busy", 64'(o_busy), 64'd0);
        watchNoValid("flush_no_valid", 80);

        // Asynchronous reset in the middle of an iteration abandons the op.
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_ALUctr = MUL; i_word_cut = 1'b0; i_src_a = 64'd3; i_src_b = 64'd4;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (20) @(posedge i_clk);
        #3 i_rst = 1'b1;
        #1;
        checkOutput("arst_ready", 64'(o_ready), 64'd1);
        checkOutput("arst_busy", 64'(o_busy), 64'd0);
        checkOutput("arst_valid", 64'(o_valid), 64'd0);
        checkOutput("arst_result", o_result, 64'd0);
        repeat (2) @(posedge i_clk);
        #2 i_rst = 1'b0;
        watchNoValid("arst_no_valid", 80);
        applyStimulus(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "post_rst_rem");
        handshake("post_rst_rem");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
